// File: rtl/mem_responder.sv
// mem_responder: word-addressed data/instruction memory for the multicycle
// core. Each MemRead/MemWrite request is latched in IDLE and then held for a
// configurable number of wait states. Completion is signalled by a one-cycle
// ready pulse, which is registered and carries err for rejected requests.
// The ready cycle also counts as busy. A request that is still present at the
// edge that closes the ready cycle is accepted at that edge.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CW-1:0] RD_CNT = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_CNT = CW'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    ERR_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic          out_of_range;
  logic          req_bad;
  logic [31:0]   mem [DEPTH_WORDS];

  // Because the depth is a power of two, a word index is out of range exactly
  // when any byte-address bit above the index field is set.
  assign out_of_range = |addr[31:AW+2];
  assign req_bad      = (mem_read & mem_write) | (addr[1:0] != 2'b00) | out_of_range;

  // Next-state logic: request capture in IDLE, wait-state countdown, and
  // the completion or error response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          addr_d  = addr[AW+1:2];
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (req_bad) begin
            state_d = ERR_RESP;
            cnt_d   = '0;
          end else if (mem_read) begin
            state_d = RD_WAIT;
            cnt_d   = RD_CNT;
          end else begin
            state_d = WR_WAIT;
            cnt_d   = WR_CNT;
          end
        end
      end

      RD_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rdata_d = mem[addr_q];
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      WR_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          mem_we  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      ERR_RESP: begin
        busy_d  = 1'b1;
        ready_d = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers. Reset abandons any request in flight
  // without producing a ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage array. Reset does not clear it, but a write that completes on a
  // reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table, hand-written multi-cycle corner
// sequences and randomized transactions checked against a behavioural memory
// model for mem_responder.
module tb_mem_responder;

  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  logic [31:0] rdata3;
  logic        ready3;
  logic        busy3;
  logic        err3;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .RD_LAT      (RD_LAT),
    .WR_LAT      (WR_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .busy      (busy),
    .err       (err)
  );

  // Second instance with a long write latency, used for the reset-before-
  // write-completion case. It shares all inputs with the main instance.
  mem_responder #(
    .DEPTH_WORDS (64),
    .RD_LAT      (1),
    .WR_LAT      (3)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata3),
    .ready     (ready3),
    .busy      (busy3),
    .err       (err3)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so that a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [31:0] exp_rdata);
    checkOutput({tag, " ready"}, 32'(ready), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
    checkOutput({tag, " rdata"}, rdata, exp_rdata);
  endtask

  task automatic doReset(input int n);
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request (called just after a negedge) and checks the wait
  // cycles and the ready cycle. It returns at the negedge inside the ready
  // cycle, with the request lines dropped.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic exp_err,
                               input logic [31:0] exp_rdata, input int exp_lat,
                               input bit scramble, input string tag);
    int bad;
    bad       = 0;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    for (int k = 1; k <= exp_lat; k++) begin
      @(negedge clk);
      if (ready !== 1'b0 || busy !== 1'b1) bad++;
      if (scramble) begin
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
      end else begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    checkOutput({tag, " wait"}, 32'(bad), 32'd0);
    checkOutput({tag, " ready"}, 32'(ready), 32'd1);
    checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " rdata"}, rdata, exp_rdata);
  endtask

  // Reference model: applies the request rules to an array memory, then
  // drives the same request into the design.
  task automatic modelTransaction(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] wd, input string tag);
    logic e;
    int   lat;
    e = (rd && wr) || (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    if (!e && wr) model_mem[int'(a >> 2)] = wd;
    if (!e && rd) model_rdata = model_mem[int'(a >> 2)];
    lat = e ? 1 : (rd ? RD_LAT : WR_LAT);
    applyStimulus(rd, wr, a, wd, e, model_rdata, lat, 1'b1, tag);
  endtask

  initial begin
    int          exp_ready6 [7];
    int          exp_busy6 [7];
    logic        seen3;
    logic [31:0] got;
    logic [31:0] got3;
    int          r;
    int          r2;
    int          w;
    logic        rd;
    logic        wr;
    logic [31:0] a;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, WR_LAT};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, RD_LAT};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, RD_LAT};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, WR_LAT};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h2222_2222, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111, RD_LAT};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h1111_1111, WR_LAT};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, RD_LAT};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0400, 32'h5555_5555, 1'b1, 32'hCAFE_F00D, 1};
    vecs[12] = '{1'b0, 1'b1, 32'h8000_0000, 32'h6666_6666, 1'b1, 32'hCAFE_F00D, 1};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111, RD_LAT};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, RD_LAT};

    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkIdle("reset", 32'h0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].exp_err,
                    vecs[i].exp_rdata, vecs[i].exp_lat, 1'b0, $sformatf("vec%0d", i));
    end
    repeat (2) @(negedge clk);
    checkIdle("idle_hold", 32'hDEAD_BEEF);

    // Reset held for two cycles in the middle of a read
    mem_read = 1'b1;
    addr     = 32'h0000_0014;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    checkOutput("midread accepted busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midread rst ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkIdle("midread after_rst", 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, RD_LAT, 1'b0,
                  "post_rst read");

    // Read held high through ready while addr/wdata toggle during busy
    exp_ready6 = '{0, 0, 1, 0, 0, 1, 0};
    exp_busy6  = '{1, 1, 1, 1, 1, 1, 0};
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    addr       = 32'h0000_0010;
    @(posedge clk);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold c%0d ready", c), 32'(ready), 32'(exp_ready6[c]));
      checkOutput($sformatf("hold c%0d busy", c), 32'(busy), 32'(exp_busy6[c]));
      if (c == 2) checkOutput("hold first rdata", rdata, 32'hDEAD_BEEF);
      if (c == 5) checkOutput("hold second rdata", rdata, 32'h1111_1111);
      wdata = $urandom;
      case (c)
        0:       addr = $urandom;
        1, 2:    addr = 32'h0000_0000;
        default: begin
          mem_read = 1'b0;
          addr     = $urandom;
        end
      endcase
    end

    // Reset one cycle before a long write completes (WR_LAT=3 instance)
    doReset(1);
    mem_write = 1'b1;
    addr      = 32'h0000_0020;
    wdata     = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    repeat (4) @(negedge clk);
    mem_write = 1'b1;
    wdata     = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    seen3     = ready3;
    @(negedge clk);
    seen3 = seen3 | ready3;
    rst   = 1'b1;
    @(negedge clk);
    seen3 = seen3 | ready3;
    rst   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen3 = seen3 | ready3;
    end
    checkOutput("rst_wr no ready", 32'(seen3), 32'd0);
    checkOutput("rst_wr busy", 32'(busy3), 32'd0);
    got       = 32'hFFFF_FFFF;
    got3      = 32'hFFFF_FFFF;
    mem_read  = 1'b1;
    addr      = 32'h0000_0020;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ready3) got3 = rdata3;
      if (ready) got = rdata;
      @(negedge clk);
    end
    checkOutput("rst_wr old value", got3, 32'hA5A5_A5A5);
    checkOutput("rst_wr main new value", got, 32'h1234_5678);

    // Randomized transactions against the behavioural model
    doReset(1);
    model_rdata = 32'h0;
    for (int i = 0; i < 32; i++) begin
      modelTransaction(1'b0, 1'b1, 32'(i) << 2, $urandom, $sformatf("init%0d", i));
    end
    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      r2 = $urandom_range(0, 9);
      w  = $urandom_range(0, 31);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      if (r2 < 7)       a = 32'(w) << 2;
      else if (r2 == 7) a = (32'(w) << 2) | 32'($urandom_range(1, 3));
      else if (r2 == 8) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1023)) << 2);
      else              a = $urandom;
      modelTransaction(rd, wr, a, $urandom, $sformatf("rnd%0d", i));
    end
    @(negedge clk);
    checkIdle("final", model_rdata);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
